// File: rtl/prbs_checker.sv
// PRBS checker for a 32-bit LFSR stream (taps 31,6,5,1): seeds from the line,
// verifies a run of matches before declaring lock, then counts errors until loss of lock.
module prbs_checker #(
    parameter int unsigned LOCK_LEN    = 64,
    parameter int unsigned WIN_LEN     = 64,
    parameter int unsigned LOSS_THRESH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        bit_in,
    input  logic        bit_valid,
    input  logic        clear_counts,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic [1:0]  state
);

    localparam int unsigned SW  = 32;
    localparam int unsigned CW  = 7;
    localparam int unsigned SCW = 6;
    localparam int unsigned EW  = 16;

    localparam logic [CW-1:0]  LOCK_LAST   = CW'(LOCK_LEN - 1);
    localparam logic [CW-1:0]  WIN_LAST    = CW'(WIN_LEN - 1);
    localparam logic [CW-1:0]  THRESH_LAST = CW'(LOSS_THRESH - 1);
    localparam logic [SCW-1:0] SEED_LAST   = SCW'(SW - 1);
    localparam logic [EW-1:0]  ERR_MAX     = '1;

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t          st;
    logic [SW-1:0]   s;
    logic [SCW-1:0]  seed_cnt;
    logic [CW-1:0]   match_cnt;
    logic [CW-1:0]   win_cnt;
    logic [CW-1:0]   werr_cnt;

    logic [SW-1:0]   s_next;
    logic            pred;
    logic            mis;
    logic            count_err;

    // The received bit always enters the history, so the checker resynchronises itself.
    assign s_next    = {s[SW-2:0], bit_in};
    assign pred      = s[31] ^ s[6] ^ s[5] ^ s[1];
    assign mis       = bit_in ^ pred;
    assign count_err = bit_valid && (st == ST_LOCKED) && mis && (err_count != ERR_MAX);
    assign state     = st;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st        <= ST_SEED;
            s         <= '0;
            seed_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            werr_cnt  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= 1'b0;

            if (bit_valid) begin
                s <= s_next;
                unique case (st)
                    ST_SEED: begin
                        if (seed_cnt == SEED_LAST) begin
                            seed_cnt <= '0;
                            // An all-zero history would predict zeros forever; reseed instead.
                            if (s_next != '0) begin
                                st        <= ST_VERIFY;
                                match_cnt <= '0;
                            end
                        end else begin
                            seed_cnt <= seed_cnt + SCW'(1);
                        end
                    end

                    ST_VERIFY: begin
                        if (mis) begin
                            st        <= ST_SEED;
                            seed_cnt  <= '0;
                            match_cnt <= '0;
                        end else if (match_cnt == LOCK_LAST) begin
                            st        <= ST_LOCKED;
                            locked    <= 1'b1;
                            match_cnt <= '0;
                            win_cnt   <= '0;
                            werr_cnt  <= '0;
                        end else begin
                            match_cnt <= match_cnt + CW'(1);
                        end
                    end

                    ST_LOCKED: begin
                        if (mis) begin
                            err_pulse <= 1'b1;
                        end
                        // Threshold check sees this bit's mismatch before any window wrap.
                        if (mis && (werr_cnt == THRESH_LAST)) begin
                            st       <= ST_SEED;
                            locked   <= 1'b0;
                            seed_cnt <= '0;
                            win_cnt  <= '0;
                            werr_cnt <= '0;
                        end else if (win_cnt == WIN_LAST) begin
                            win_cnt  <= '0;
                            werr_cnt <= '0;
                        end else begin
                            win_cnt <= win_cnt + CW'(1);
                            if (mis) begin
                                werr_cnt <= werr_cnt + CW'(1);
                            end
                        end
                    end

                    default: begin
                        st        <= ST_SEED;
                        locked    <= 1'b0;
                        seed_cnt  <= '0;
                        match_cnt <= '0;
                        win_cnt   <= '0;
                        werr_cnt  <= '0;
                    end
                endcase
            end

            // Clear wins over a coincident increment.
            if (clear_counts) begin
                err_count <= '0;
            end else if (count_err) begin
                err_count <= err_count + EW'(1);
            end
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Randomised bench for prbs_checker: two instances (default and wide-window) checked
// every cycle against a behavioural model, plus literal checkpoints.
module tb_prbs_checker;

    localparam int unsigned L1 = 2;
    localparam int unsigned W1 = 127;
    localparam int unsigned T1 = 127;
    localparam logic [31:0] SEED = 32'h8EAF696C;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic bit_in = 1'b0;
    logic bit_valid = 1'b0;
    logic clear_counts = 1'b0;

    logic        u0_locked, u0_err_pulse, u1_locked, u1_err_pulse;
    logic [15:0] u0_err_count, u1_err_count;
    logic [1:0]  u0_state, u1_state;

    int errors = 0;
    int checks = 0;

    prbs_checker u0 (
        .clock(clock), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .clear_counts(clear_counts), .locked(u0_locked), .err_pulse(u0_err_pulse),
        .err_count(u0_err_count), .state(u0_state)
    );

    prbs_checker #(.LOCK_LEN(L1), .WIN_LEN(W1), .LOSS_THRESH(T1)) u1 (
        .clock(clock), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .clear_counts(clear_counts), .locked(u1_locked), .err_pulse(u1_err_pulse),
        .err_count(u1_err_count), .state(u1_state)
    );

    always #5 clock = ~clock;

    // Behavioural model: mode 0 seed, 1 verify, 2 locked; h holds the last 32 accepted bits.
    typedef struct packed {
        int        mode;
        int        seed_n;
        int        match_n;
        int        win_n;
        int        werr_n;
        int        err_count;
        bit        pulse;
        bit [31:0] h;
    } mdl_t;

    mdl_t m0 = '0;
    mdl_t m1 = '0;
    bit [31:0] g;

    function automatic bit mdl_pred(mdl_t m);
        return m.h[31] ^ m.h[6] ^ m.h[5] ^ m.h[1];
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, bit b, bit v, bit clr,
                                      int lock_len, int win_len, int thresh);
        mdl_t n = m;
        bit miss;
        n.pulse = 1'b0;
        if (v) begin
            miss = (b != mdl_pred(m));
            n.h = {m.h[30:0], b};
            if (m.mode == 0) begin
                n.seed_n = m.seed_n + 1;
                if (n.seed_n == 32) begin
                    n.seed_n = 0;
                    if (n.h != 32'd0) begin
                        n.mode = 1;
                        n.match_n = 0;
                    end
                end
            end else if (m.mode == 1) begin
                if (miss) begin
                    n.mode = 0; n.seed_n = 0; n.match_n = 0;
                end else begin
                    n.match_n = m.match_n + 1;
                    if (n.match_n == lock_len) begin
                        n.mode = 2; n.match_n = 0; n.win_n = 0; n.werr_n = 0;
                    end
                end
            end else begin
                if (miss) begin
                    n.pulse = 1'b1;
                    if (!clr && m.err_count < 65535) n.err_count = m.err_count + 1;
                    n.werr_n = m.werr_n + 1;
                end
                n.win_n = m.win_n + 1;
                if (n.werr_n == thresh) begin
                    n.mode = 0; n.seed_n = 0; n.win_n = 0; n.werr_n = 0;
                end else if (n.win_n == win_len) begin
                    n.win_n = 0; n.werr_n = 0;
                end
            end
        end
        if (clr) n.err_count = 0;
        return n;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m0 = '0;
            m1 = '0;
        end else begin
            m0 = mdl_step(m0, bit_in, bit_valid, clear_counts, 64, 64, 8);
            m1 = mdl_step(m1, bit_in, bit_valid, clear_counts, L1, W1, T1);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of both instances against the model.
    always @(negedge clock) begin
        chk("u0_state", 32'(u0_state), 32'(m0.mode));
        chk("u0_locked", 32'(u0_locked), 32'(m0.mode == 2));
        chk("u0_err_pulse", 32'(u0_err_pulse), 32'(m0.pulse));
        chk("u0_err_count", 32'(u0_err_count), 32'(m0.err_count));
        chk("u1_state", 32'(u1_state), 32'(m1.mode));
        chk("u1_locked", 32'(u1_locked), 32'(m1.mode == 2));
        chk("u1_err_pulse", 32'(u1_err_pulse), 32'(m1.pulse));
        chk("u1_err_count", 32'(u1_err_count), 32'(m1.err_count));
    end

    task automatic gen(output bit b);
        b = g[31];
        g = {g[30:0], g[31] ^ g[6] ^ g[5] ^ g[1]};
    endtask

    task automatic cycle(input bit b, input bit v, input bit clr);
        bit_in = b;
        bit_valid = v;
        clear_counts = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        bit_valid = 1'b0;
        clear_counts = 1'b0;
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, "_locked0"}, 32'(u0_locked), 32'd0);
        chk({tag, "_pulse0"}, 32'(u0_err_pulse), 32'd0);
        chk({tag, "_count0"}, 32'(u0_err_count), 32'd0);
        chk({tag, "_state0"}, 32'(u0_state), 32'd0);
        chk({tag, "_locked1"}, 32'(u1_locked), 32'd0);
        chk({tag, "_pulse1"}, 32'(u1_err_pulse), 32'd0);
        chk({tag, "_count1"}, 32'(u1_err_count), 32'd0);
        chk({tag, "_state1"}, 32'(u1_state), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit b;
        bit [63:0] pos;
        int n;
        int nvalid;
        int guard;

        repeat (2) @(posedge clock);
        #1;
        outputs_zero("reset");
        reset = 1'b1;

        // Clean stream from the reference seed: verify after 32 bits, lock on bit 96.
        g = SEED;
        for (int i = 1; i <= 96; i++) begin
            gen(b);
            cycle(b, 1'b1, 1'b0);
            if (i == 31) chk("seed_31", 32'(u0_state), 32'd0);
            if (i == 32) chk("verify_32", 32'(u0_state), 32'd1);
            if (i == 95) chk("unlocked_95", 32'(u0_locked), 32'd0);
            if (i == 96) begin
                chk("locked_96", 32'(u0_locked), 32'd1);
                chk("clean_count", 32'(u0_err_count), 32'd0);
            end
        end

        // Single flipped bit while locked.
        repeat ($urandom_range(0, 20)) begin
            gen(b);
            cycle(b, 1'b1, 1'b0);
        end
        gen(b);
        cycle(~b, 1'b1, 1'b0);
        chk("flip_pulse", 32'(u0_err_pulse), 32'd1);
        chk("flip_count", 32'(u0_err_count), 32'd1);
        chk("flip_locked", 32'(u0_locked), 32'd1);
        gen(b);
        cycle(b, 1'b1, 1'b0);
        chk("flip_pulse_drop", 32'(u0_err_pulse), 32'd0);
        repeat (50) begin
            gen(b);
            cycle(b, 1'b1, 1'b0);
        end
        chk("flip_still_locked", 32'(u0_locked), 32'd1);

        // Eight injected mismatches inside one window force loss of lock.
        guard = 0;
        while (m0.win_n != 0 && guard < 200) begin
            gen(b);
            cycle(b, 1'b1, 1'b0);
            guard++;
        end
        pos = '0;
        n = 0;
        while (n < 8) begin
            int p;
            p = int'($urandom_range(0, 63));
            if (!pos[p]) begin
                pos[p] = 1'b1;
                n++;
            end
        end
        n = 0;
        for (int k = 0; k < 64; k++) begin
            if (pos[k]) begin
                cycle(~mdl_pred(m0), 1'b1, 1'b0);
                n++;
                chk("inject_pulse", 32'(u0_err_pulse), 32'd1);
                if (n < 8) begin
                    chk("inject_held", 32'(u0_locked), 32'd1);
                end else begin
                    chk("inject_lost", 32'(u0_locked), 32'd0);
                    chk("inject_seed", 32'(u0_state), 32'd0);
                    break;
                end
            end else begin
                cycle(mdl_pred(m0), 1'b1, 1'b0);
            end
        end
        for (int i = 1; i <= 96; i++) begin
            gen(b);
            cycle(b, 1'b1, 1'b0);
            if (i == 95) chk("relock_95", 32'(u0_locked), 32'd0);
            if (i == 96) chk("relock_96", 32'(u0_locked), 32'd1);
        end

        // Random bit_valid gaps: same lock point counted in valid bits.
        do_reset();
        g = SEED;
        nvalid = 0;
        guard = 0;
        while (nvalid < 96 && guard < 2000) begin
            bit v;
            v = 1'($urandom_range(0, 1));
            if (v) gen(b);
            else b = 1'($urandom);
            cycle(b, v, 1'b0);
            guard++;
            if (v) begin
                nvalid++;
                if (nvalid == 32) chk("gap_verify_32", 32'(u0_state), 32'd1);
                if (nvalid == 95) chk("gap_unlocked_95", 32'(u0_locked), 32'd0);
            end
        end
        chk("gap_locked_96", 32'(u0_locked), 32'd1);
        chk("gap_count", 32'(u0_err_count), 32'd0);

        // All-zero input is rejected as a seed.
        do_reset();
        for (int i = 1; i <= 40; i++) begin
            cycle(1'b0, 1'b1, 1'b0);
            if ($urandom_range(0, 3) == 0) cycle(1'b1, 1'b0, 1'b0);
        end
        chk("zero_state", 32'(u0_state), 32'd0);
        chk("zero_locked", 32'(u0_locked), 32'd0);

        // Drive the wide-window instance to saturation: mismatch on every bit but the window's last.
        do_reset();
        g = $urandom | 32'd1;
        guard = 0;
        while (m1.err_count != 65535 && guard < 70000) begin
            if (m1.mode == 0) gen(b);
            else if (m1.mode == 1) b = mdl_pred(m1);
            else b = (m1.win_n == int'(W1) - 1) ? mdl_pred(m1) : ~mdl_pred(m1);
            cycle(b, 1'b1, 1'b0);
            guard++;
        end
        chk("sat_reach", 32'(u1_err_count), 32'hFFFF);
        for (int i = 0; i < 3; i++) begin
            if (m1.win_n == int'(W1) - 1) cycle(mdl_pred(m1), 1'b1, 1'b0);
            cycle(~mdl_pred(m1), 1'b1, 1'b0);
            chk("sat_hold", 32'(u1_err_count), 32'hFFFF);
            chk("sat_pulse", 32'(u1_err_pulse), 32'd1);
        end
        if (m1.win_n == int'(W1) - 1) cycle(mdl_pred(m1), 1'b1, 1'b0);
        cycle(~mdl_pred(m1), 1'b1, 1'b1);
        chk("clear_count", 32'(u1_err_count), 32'd0);
        chk("clear_pulse", 32'(u1_err_pulse), 32'd1);

        // Asynchronous reset mid-window clears outputs without waiting for a clock edge.
        repeat (5) cycle(~mdl_pred(m1), 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        outputs_zero("async");
        @(posedge clock);
        #1;
        reset = 1'b1;
        g = SEED;
        for (int i = 1; i <= 32; i++) begin
            gen(b);
            cycle(b, 1'b1, 1'b0);
            if (i == 31) chk("post_rst_31", 32'(u0_state), 32'd0);
        end
        chk("post_rst_32", 32'(u0_state), 32'd1);

        cycle(1'b0, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
